mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single BRAM memory controller between the UART RX path (writer) and the UART TX path (reader) in the BRAM loop-back design.
- Serialises requests into one-transaction-at-a-time En/DataReady handshakes on the memory-controller side.
- Returns a per-requester completion pulse and captured read data.

Parameters:
- ADDR_W, 4, address width to the memory controller.
- DATA_W, 8, data width.
- TIMEOUT, 15, cycles in WAIT before abort (only with optional feature; range 1..255).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Req0 / Req1  in  1  request, held high until matching Done pulse.
- We0 / We1  in  1  1 = write, 0 = read; sampled at grant.
- Addr0 / Addr1  in  ADDR_W  address; sampled at grant.
- Wdata0 / Wdata1  in  DATA_W  write data; sampled at grant.
- Gnt0 / Gnt1  out  1  high from ISSUE through DONE for the owning requester.
- Done0 / Done1  out  1  one-cycle completion pulse.
- Rdata  out  DATA_W  read data, valid from the Done pulse until the next read completes.
- MemEn  out  1  one-cycle start pulse to the memory controller.
- MemWe  out  1  write enable to the memory controller.
- MemAddr  out  ADDR_W  address to the memory controller.
- MemDin  out  DATA_W  write data to the memory controller.
- MemDout  in  DATA_W  read data from the memory controller.
- MemReady  in  1  memory controller DataReady (level; cleared on accept, set on finish).

Behaviour:
- Reset values:
  - All outputs are 0; Rdata is 0; state is IDLE.
  - Priority pointer is 0, so requester 0 wins the first tie.
  - MemReady history register is 1.
- Reset mid-transaction:
  - Immediate return to IDLE with all outputs 0.
  - An in-flight memory operation is abandoned; its later DataReady is not reported to anyone.
- Completion event: MemReady sampled 1 while its registered previous sample is 0.
  - The history register updates every cycle, including in IDLE.
  - Stale high levels therefore never count as completion.
- IDLE:
  - If any ReqN is high, select the winner: sole requester, or, when both request, the requester not served last (pointer).
  - Latch We/Addr/Wdata of the winner into MemWe/MemAddr/MemDin, assert GntN, go to ISSUE.
- ISSUE: MemEn = 1 for exactly this cycle; go to WAIT.
- WAIT:
  - Hold GntN, MemWe, MemAddr and MemDin stable.
  - On the completion event: if the operation was a read, capture MemDout into Rdata. Go to DONE.
- DONE:
  - DoneN = 1 for one cycle; GntN drops at the end of this cycle.
  - Pointer is set to the other requester; MemWe is cleared; return to IDLE.
- Back-to-back: a requester still holding Req in the cycle after DONE is eligible again.
  - With both requesting, grants strictly alternate 0,1,0,1.
- ReqN deasserted mid-transaction: ignored; the transaction completes and DoneN still pulses.
- Write transactions leave Rdata unchanged.
- Latency: Req high at edge k gives MemEn high in cycle k+1. Done pulses the cycle after the completion event is detected.

Optional Feature:
- MEM_ARB_TIMEOUT_EN defined:
  - An 8-bit counter runs in WAIT.
  - If TIMEOUT cycles elapse with no completion event, go to DONE and pulse DoneN together with an extra output TimeoutErr (1 cycle).
  - Rdata is not updated on a timeout.
  - The counter clears on entry to WAIT and on reset.
- MEM_ARB_TIMEOUT_EN undefined: no TimeoutErr port; WAIT is unbounded.

Test Plan:
- Reset: Rst_n low mid-WAIT -> all outputs 0 at once; after release, Req0 write Addr0=4'h3, Wdata0=8'hA5 -> MemEn pulse once, MemAddr=3, MemDin=A5, MemWe=1, Done0 pulse, Gnt1 never high.
- Single read: Req1 read Addr1=4'h3 after the write above -> Rdata=8'hA5 at Done1; exactly one MemEn pulse.
- Contention: Req0 and Req1 raised in the same cycle and both held for 4 transactions -> grant order 0,1,0,1; never two Gnt high; never two MemEn pulses without an intervening MemReady edge.
- Request drop: Req0 deasserted the cycle after Gnt0 -> transaction completes; Done0 pulses; MemAddr stays stable throughout WAIT.
- Stale ready: MemReady held at 1 before the request -> no Done until MemReady goes 0 then 1.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=15): MemReady stuck 0 -> Done0 and TimeoutErr pulse 15 cycles after WAIT entry; Rdata unchanged.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-controller signals shared by mem_arbiter
// Carries timeout_err only when MEM_ARB_TIMEOUT_EN is defined
interface mem_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, done0, done1;
    logic [DATA_W-1:0] rdata;
    logic              mem_en, mem_we, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din, mem_dout;
`ifdef MEM_ARB_TIMEOUT_EN
    logic              timeout_err;
`endif

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout, mem_ready,
`ifdef MEM_ARB_TIMEOUT_EN
        output timeout_err,
`endif
        output gnt0, gnt1, done0, done1, rdata, mem_en, mem_we, mem_addr, mem_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout, mem_ready,
`ifdef MEM_ARB_TIMEOUT_EN
        input  timeout_err,
`endif
        input  gnt0, gnt1, done0, done1, rdata, mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one BRAM controller between a writer and a reader
// Defining MEM_ARB_TIMEOUT_EN bounds WAIT to TIMEOUT cycles and adds timeout_err
module mem_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d, ptr_q, ptr_d, we_q, we_d, rdy_prev_q, rdy_prev_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d, rdata_q, rdata_d;
    logic              evt, pick, tmo;

    // Completion is a rising edge of the level DataReady, so a stale high never counts
    assign evt  = bus.mem_ready && !rdy_prev_q;
    assign pick = (bus.req0 && bus.req1) ? ptr_q : bus.req1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        we_d       = we_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rdata_d    = rdata_q;
        rdy_prev_d = bus.mem_ready;
        case (state_q)
            IDLE: if (bus.req0 || bus.req1) begin
                state_d = ISSUE;
                owner_d = pick;
                we_d    = pick ? bus.we1 : bus.we0;
                addr_d  = pick ? bus.addr1 : bus.addr0;
                din_d   = pick ? bus.wdata1 : bus.wdata0;
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = (evt || tmo) ? DONE : WAIT;
                rdata_d = (evt && !we_q) ? bus.mem_dout : rdata_q;
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = !owner_q;
                we_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            ptr_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            rdata_q    <= '0;
            rdy_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rdata_q    <= rdata_d;
            rdy_prev_q <= rdy_prev_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       to_q, to_d;

    // Counter sits at zero outside WAIT, so it is clear on every WAIT entry
    assign tmo = (state_q == WAIT) && (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        cnt_d = (state_q == WAIT) ? cnt_q + 8'd1 : 8'd0;
        to_d  = tmo && !evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign bus.timeout_err = (state_q == DONE) && to_q;
`else
    logic unused_timeout;
    assign tmo            = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    assign bus.gnt0     = (state_q != IDLE) && !owner_q;
    assign bus.gnt1     = (state_q != IDLE) && owner_q;
    assign bus.done0    = (state_q == DONE) && !owner_q;
    assign bus.done1    = (state_q == DONE) && owner_q;
    assign bus.mem_en   = (state_q == ISSUE);
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of reset, single ops, alternation, request drop, stale ready
// and, with MEM_ARB_TIMEOUT_EN, the WAIT timeout
module tb_mem_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0] mem [16];
    int            o_en, o_en_cyc, o_d0, o_d1, o_g0, o_g1, o_both, o_achg, o_extra, o_tmo;
    logic [AW-1:0] o_addr_cap;
    logic [DW-1:0] o_din_cap, o_rd;
    logic          o_we_cap;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(15)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Plays the memory controller for one transaction: drops ready on accept, raises it lat cycles later
    task automatic xact(input int lat, input bit drop0);
        int cnt = 0;
        bit waiting = 0;
        o_en = 0; o_en_cyc = 0; o_d0 = 0; o_d1 = 0; o_g0 = 0; o_g1 = 0;
        o_both = 0; o_achg = 0; o_extra = 0; o_tmo = 1; o_rd = '0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (bus.gnt0 && bus.gnt1) o_both++;
            if (bus.gnt0) o_g0 = 1;
            if (bus.gnt1) o_g1 = 1;
            if (bus.done0 || bus.done1) begin
                o_d0  = int'(bus.done0);
                o_d1  = int'(bus.done1);
                o_rd  = bus.rdata;
                o_tmo = 0;
                tick();
                o_extra = int'(bus.done0 || bus.done1);
                break;
            end
            if (bus.mem_en) begin
                o_en++;
                if (o_en_cyc == 0) o_en_cyc = i;
                o_addr_cap = bus.mem_addr;
                o_din_cap  = bus.mem_din;
                o_we_cap   = bus.mem_we;
                bus.mem_ready = 1'b0;
                cnt = lat;
                waiting = 1;
            end else if (waiting) begin
                if (bus.mem_addr !== o_addr_cap || bus.mem_din !== o_din_cap) o_achg++;
                if (drop0 && cnt == lat) bus.req0 = 1'b0;
                cnt--;
                if (cnt == 0) begin
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_din;
                    else bus.mem_dout = mem[bus.mem_addr];
                    bus.mem_ready = 1'b1;
                    waiting = 0;
                end
            end
        end
    endtask

    task automatic test_reset;
        int dn = 0;
        #2 rst_n = 1'b0;
        tick(); tick();
        total++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_en, bus.mem_we} !== 6'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=000000",
                {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_en, bus.mem_we});
        end
        total++;
        if ({bus.rdata, bus.mem_addr, bus.mem_din} !== 20'h0) begin
            bad++; $display("FAIL reset_data got=%h exp=0", {bus.rdata, bus.mem_addr, bus.mem_din});
        end
        rst_n = 1'b1;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'hC; bus.wdata1 = 8'h77;
        tick();
        total++;
        if (bus.mem_en !== 1'b1 || bus.gnt1 !== 1'b1) begin
            bad++; $display("FAIL reset_pre_issue en=%b gnt1=%b exp=1,1", bus.mem_en, bus.gnt1);
        end
        bus.mem_ready = 1'b0;
        tick(); tick();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 4'hC) begin
            bad++; $display("FAIL reset_pre_wait we=%b addr=%h exp=1,c", bus.mem_we, bus.mem_addr);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.mem_en, bus.mem_we} !== 6'b0 ||
            {bus.rdata, bus.mem_addr, bus.mem_din} !== 20'h0) begin
            bad++; $display("FAIL reset_mid_wait gnt1=%b we=%b addr=%h din=%h exp all 0",
                bus.gnt1, bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        bus.req1 = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (4) begin
            tick();
            if (bus.done0 || bus.done1 || bus.mem_en) dn++;
        end
        total++;
        if (dn !== 0) begin
            bad++; $display("FAIL reset_abandoned got=%0d exp=0", dn);
        end
    endtask

    task automatic test_write;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h3; bus.wdata0 = 8'hA5;
        xact(2, 0);
        bus.req0 = 1'b0;
        total++;
        if (o_en !== 1 || o_en_cyc !== 1) begin
            bad++; $display("FAIL write_en count=%0d cyc=%0d exp=1,1", o_en, o_en_cyc);
        end
        total++;
        if (o_addr_cap !== 4'h3 || o_din_cap !== 8'hA5 || o_we_cap !== 1'b1) begin
            bad++; $display("FAIL write_bus addr=%h din=%h we=%b exp=3,a5,1", o_addr_cap, o_din_cap, o_we_cap);
        end
        total++;
        if (o_d0 !== 1 || o_d1 !== 0 || o_tmo !== 0) begin
            bad++; $display("FAIL write_done d0=%0d d1=%0d tmo=%0d exp=1,0,0", o_d0, o_d1, o_tmo);
        end
        total++;
        if (o_g1 !== 0 || o_extra !== 0) begin
            bad++; $display("FAIL write_gnt1 g1=%0d extra=%0d exp=0,0", o_g1, o_extra);
        end
        total++;
        if (bus.mem_we !== 1'b0 || bus.gnt0 !== 1'b0) begin
            bad++; $display("FAIL write_after we=%b gnt0=%b exp=0,0", bus.mem_we, bus.gnt0);
        end
    endtask

    task automatic test_read;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'h3;
        xact(3, 0);
        bus.req1 = 1'b0;
        total++;
        if (o_d1 !== 1 || o_d0 !== 0 || o_rd !== 8'hA5) begin
            bad++; $display("FAIL read_done d1=%0d rdata=%h exp=1,a5", o_d1, o_rd);
        end
        total++;
        if (o_en !== 1 || o_g0 !== 0) begin
            bad++; $display("FAIL read_en count=%0d g0=%0d exp=1,0", o_en, o_g0);
        end
        total++;
        if (bus.rdata !== 8'hA5) begin
            bad++; $display("FAIL read_hold rdata=%h exp=a5", bus.rdata);
        end
    endtask

    task automatic test_contention;
        int exp_own[4] = '{0, 1, 0, 1};
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h5; bus.wdata0 = 8'h3C;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'h5;
        for (int k = 0; k < 4; k++) begin
            xact(2, 0);
            total++;
            if (o_d1 !== exp_own[k] || o_d0 !== 1 - exp_own[k]) begin
                bad++; $display("FAIL contend_order%0d d0=%0d d1=%0d exp_owner=%0d", k, o_d0, o_d1, exp_own[k]);
            end
            total++;
            if (o_both !== 0 || o_en !== 1) begin
                bad++; $display("FAIL contend_excl%0d both=%0d en=%0d exp=0,1", k, o_both, o_en);
            end
            if (exp_own[k] == 1) begin
                total++;
                if (o_rd !== 8'h3C) begin
                    bad++; $display("FAIL contend_rdata%0d got=%h exp=3c", k, o_rd);
                end
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    task automatic test_req_drop;
        int en = 0;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'h7; bus.wdata0 = 8'h11;
        xact(4, 1);
        total++;
        if (o_d0 !== 1 || o_tmo !== 0) begin
            bad++; $display("FAIL drop_done d0=%0d tmo=%0d exp=1,0", o_d0, o_tmo);
        end
        total++;
        if (o_achg !== 0 || o_addr_cap !== 4'h7) begin
            bad++; $display("FAIL drop_addr changes=%0d addr=%h exp=0,7", o_achg, o_addr_cap);
        end
        repeat (3) begin
            tick();
            if (bus.mem_en) en++;
        end
        total++;
        if (en !== 0 || bus.rdata !== 8'h3C) begin
            bad++; $display("FAIL drop_after en=%0d rdata=%h exp=0,3c", en, bus.rdata);
        end
    endtask

    task automatic test_stale;
        int dn = 0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 4'h7;
        tick();
        total++;
        if (bus.mem_en !== 1'b1) begin
            bad++; $display("FAIL stale_issue got=%b exp=1", bus.mem_en);
        end
        repeat (6) begin
            tick();
            if (bus.done0 || bus.done1) dn++;
        end
        total++;
        if (dn !== 0) begin
            bad++; $display("FAIL stale_early got=%0d exp=0", dn);
        end
        bus.mem_ready = 1'b0;
        tick();
        bus.mem_dout  = 8'h11;
        bus.mem_ready = 1'b1;
        tick();
        total++;
        if (bus.done1 !== 1'b1 || bus.rdata !== 8'h11) begin
            bad++; $display("FAIL stale_done done1=%b rdata=%h exp=1,11", bus.done1, bus.rdata);
        end
        bus.req1 = 1'b0;
        tick();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int   first = 0;
        logic te = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'h7; bus.mem_dout = 8'hEE;
        tick();
        bus.mem_ready = 1'b0;
        for (int i = 2; i <= 40; i++) begin
            tick();
            if (bus.done0) begin
                first = i;
                te = bus.timeout_err;
                break;
            end
        end
        total++;
        if (first !== 17 || te !== 1'b1) begin
            bad++; $display("FAIL timeout_cycle got=%0d err=%b exp=17,1", first, te);
        end
        total++;
        if (bus.rdata !== 8'h11) begin
            bad++; $display("FAIL timeout_rdata got=%h exp=11", bus.rdata);
        end
        bus.req0 = 1'b0;
        tick();
        total++;
        if (bus.timeout_err !== 1'b0 || bus.done0 !== 1'b0) begin
            bad++; $display("FAIL timeout_pulse err=%b done0=%b exp=0,0", bus.timeout_err, bus.done0);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.mem_dout = '0; bus.mem_ready = 1'b1;
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_req_drop();
        test_stale();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
